// File: rtl/tl_rx_demux.sv
// Transaction-layer receive demultiplexer: classifies TLPs coming off the DLL Rx
// path, steers header/payload beats to the TL request lanes and drops the rest.
module tl_rx_demux #(
    parameter int MAX_PAYLOAD_SIZE = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         link_active_i,
    input  logic         tlp_valid_i,
    input  logic         tlp_sop_i,
    input  logic [255:0] tlp_i,
    output logic [255:0] tlp_o,
    output logic [2:0]   req_o,
    output logic         drop_pulse_o,
    output logic [7:0]   drop_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_P_DATA,
        S_CPL_DATA,
        S_DROP
    } state_t;

    localparam logic [2:0] REQ_IDLE     = 3'd0;
    localparam logic [2:0] REQ_P_HDR    = 3'd1;
    localparam logic [2:0] REQ_P_DATA   = 3'd2;
    localparam logic [2:0] REQ_NP_HDR   = 3'd3;
    localparam logic [2:0] REQ_CPL_HDR  = 3'd5;
    localparam logic [2:0] REQ_CPL_DATA = 3'd6;

    localparam logic [4:0] TYPE_MEM = 5'b00000;
    localparam logic [4:0] TYPE_CPL = 5'b01010;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [255:0] tlp_q, tlp_d;
    logic [2:0]   req_q, req_d;
    logic         drop_pulse_q, drop_pulse_d;
    logic [7:0]   drop_cnt_q, drop_cnt_d;

    logic [2:0]   fmt;
    logic [4:0]   typ;
    logic [10:0]  len_dw;
    logic [7:0]   hdr_beats;
    logic         hdr_oversize;
    logic         is_mwr, is_mrd, is_cpl, is_cpld;

    state_t       hdr_state;
    logic [7:0]   hdr_cnt;
    logic [2:0]   hdr_req;
    logic         hdr_drop;

    logic         trunc_drop;
    logic [1:0]   drops;

    // Header field decode, evaluated on every beat and used only when sop is set.
    always_comb begin
        fmt          = tlp_i[7:5];
        typ          = tlp_i[4:0];
        len_dw       = ({tlp_i[17:16], tlp_i[31:24]} == 10'd0) ? 11'd1024
                                                               : {1'b0, tlp_i[17:16], tlp_i[31:24]};
        hdr_beats    = len_dw[10:3] + {7'd0, |len_dw[2:0]};
        hdr_oversize = ({19'd0, len_dw, 2'b00} > 32'(MAX_PAYLOAD_SIZE));
        is_mwr       = (fmt == 3'b010 || fmt == 3'b011) && (typ == TYPE_MEM);
        is_mrd       = (fmt == 3'b000 || fmt == 3'b001) && (typ == TYPE_MEM);
        is_cpl       = (fmt == 3'b000) && (typ == TYPE_CPL);
        is_cpld      = (fmt == 3'b010) && (typ == TYPE_CPL);
    end

    // Outcome of accepting this beat as a new header, independent of current state.
    always_comb begin
        hdr_state = S_IDLE;
        hdr_cnt   = 8'd0;
        hdr_req   = REQ_IDLE;
        hdr_drop  = 1'b0;
        if (is_mwr) begin
            hdr_cnt = hdr_beats;
            if (hdr_oversize) begin
                hdr_drop  = 1'b1;
                hdr_state = S_DROP;
            end else begin
                hdr_req   = REQ_P_HDR;
                hdr_state = S_P_DATA;
            end
        end else if (is_mrd) begin
            hdr_req = REQ_NP_HDR;
        end else if (is_cpl) begin
            hdr_req = REQ_CPL_HDR;
        end else if (is_cpld) begin
            hdr_cnt = hdr_beats;
            if (hdr_oversize) begin
                hdr_drop  = 1'b1;
                hdr_state = S_DROP;
            end else begin
                hdr_req   = REQ_CPL_HDR;
                hdr_state = S_CPL_DATA;
            end
        end else begin
            hdr_drop = 1'b1;
            // Unsupported but claims a payload: swallow it so it is not seen as orphans.
            if (fmt[1]) begin
                hdr_state = S_DROP;
                hdr_cnt   = hdr_beats;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = REQ_IDLE;
        trunc_drop = 1'b0;
        drops      = 2'd0;
        if (!link_active_i) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else if (tlp_valid_i) begin
            if (tlp_sop_i) begin
                // A header arriving mid-TLP truncates the old one and is decoded as usual.
                trunc_drop = (state_q != S_IDLE);
                state_d    = hdr_state;
                cnt_d      = hdr_cnt;
                req_d      = hdr_req;
                drops      = {1'b0, trunc_drop} + {1'b0, hdr_drop};
            end else if (state_q != S_IDLE) begin
                if (state_q == S_P_DATA) begin
                    req_d = REQ_P_DATA;
                end else if (state_q == S_CPL_DATA) begin
                    req_d = REQ_CPL_DATA;
                end
                if (cnt_q <= 8'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        end
        tlp_d        = (req_d != REQ_IDLE) ? tlp_i : '0;
        drop_pulse_d = (drops != 2'd0);
        drop_cnt_d   = sat_add(drop_cnt_q, drops);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            tlp_q        <= '0;
            req_q        <= REQ_IDLE;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tlp_q        <= tlp_d;
            req_q        <= req_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign tlp_o        = tlp_q;
    assign req_o        = req_q;
    assign drop_pulse_o = drop_pulse_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_tl_rx_demux.sv
// Scoreboard bench for tl_rx_demux: each driven beat queues its expected output,
// which is compared one cycle later.
module tb_tl_rx_demux;

    localparam logic [2:0] R_IDLE = 3'd0;
    localparam logic [2:0] R_PH   = 3'd1;
    localparam logic [2:0] R_PD   = 3'd2;
    localparam logic [2:0] R_NP   = 3'd3;
    localparam logic [2:0] R_CH   = 3'd5;
    localparam logic [2:0] R_CD   = 3'd6;

    localparam logic [2:0] F_3DW   = 3'b000;
    localparam logic [2:0] F_3DW_D = 3'b010;
    localparam logic [2:0] F_4DW_D = 3'b011;
    localparam logic [4:0] T_MEM   = 5'b00000;
    localparam logic [4:0] T_CPL   = 5'b01010;
    localparam logic [4:0] T_BAD   = 5'b00100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         link_active_i;
    logic         tlp_valid_i;
    logic         tlp_sop_i;
    logic [255:0] tlp_i;
    logic [255:0] tlp_o;
    logic [2:0]   req_o;
    logic         drop_pulse_o;
    logic [7:0]   drop_cnt_o;

    typedef struct {
        int           due;
        logic [2:0]   req;
        logic [255:0] tlp;
        logic         pulse;
        logic [7:0]   cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   exp_cnt = 0;
    bit   lk_want = 1'b1;

    tl_rx_demux #(.MAX_PAYLOAD_SIZE(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .link_active_i(link_active_i),
        .tlp_valid_i  (tlp_valid_i),
        .tlp_sop_i    (tlp_sop_i),
        .tlp_i        (tlp_i),
        .tlp_o        (tlp_o),
        .req_o        (req_o),
        .drop_pulse_o (drop_pulse_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check($sformatf("req@%0d", mon_e.due),   {253'd0, req_o},       {253'd0, mon_e.req});
            check($sformatf("tlp@%0d", mon_e.due),   tlp_o,                 mon_e.tlp);
            check($sformatf("pulse@%0d", mon_e.due), {255'd0, drop_pulse_o}, {255'd0, mon_e.pulse});
            check($sformatf("cnt@%0d", mon_e.due),   {248'd0, drop_cnt_o},  {248'd0, mon_e.cnt});
        end
    end

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] hdr(input logic [2:0] fmt, input logic [4:0] typ,
                                         input logic [9:0] len);
        logic [255:0] h;
        h        = rnd();
        h[7:5]   = fmt;
        h[4:0]   = typ;
        h[17:16] = len[9:8];
        h[31:24] = len[7:0];
        return h;
    endfunction

    task automatic beat(input logic v, input logic sop, input logic [255:0] d,
                        input logic [2:0] ereq, input int edrops);
        exp_t x;
        @(posedge clk);
        #1;
        link_active_i = lk_want;
        tlp_valid_i   = v;
        tlp_sop_i     = sop;
        tlp_i         = d;
        exp_cnt       = (exp_cnt + edrops > 255) ? 255 : exp_cnt + edrops;
        x.due   = cyc + 1;
        x.req   = ereq;
        x.tlp   = (ereq != R_IDLE) ? d : '0;
        x.pulse = (edrops != 0);
        x.cnt   = exp_cnt[7:0];
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, rnd(), R_IDLE, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        link_active_i = 1'b1;
        tlp_valid_i = 1'b0;
        tlp_sop_i = 1'b0;
        tlp_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   {253'd0, req_o},        256'd0);
        check("rst_tlp",   tlp_o,                  256'd0);
        check("rst_pulse", {255'd0, drop_pulse_o}, 256'd0);
        check("rst_cnt",   {248'd0, drop_cnt_o},   256'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // MWr len=32 accepted at exactly MAX_PAYLOAD_SIZE, 4 payload beats
        beat(1, 1, hdr(F_3DW_D, T_MEM, 10'd32), R_PH, 0);
        for (int i = 0; i < 4; i++) beat(1, 0, rnd(), R_PD, 0);
        beat(1, 0, rnd(), R_IDLE, 0);
        idle(1);

        // MRd then CplD len=9 with a 3-cycle valid gap between payload beats
        beat(1, 1, hdr(F_3DW, T_MEM, 10'd1), R_NP, 0);
        beat(1, 1, hdr(F_3DW_D, T_CPL, 10'd9), R_CH, 0);
        beat(1, 0, rnd(), R_CD, 0);
        idle(3);
        beat(1, 0, rnd(), R_CD, 0);
        beat(1, 0, rnd(), R_IDLE, 0);

        // Oversize MWr len=64: dropped, 8 beats swallowed, next MRd not a truncation
        beat(1, 1, hdr(F_3DW_D, T_MEM, 10'd64), R_IDLE, 1);
        for (int i = 0; i < 8; i++) beat(1, 0, rnd(), R_IDLE, 0);
        beat(1, 1, hdr(F_3DW, T_MEM, 10'd2), R_NP, 0);

        // Oversize by one DW: 5 beats swallowed
        beat(1, 1, hdr(F_4DW_D, T_MEM, 10'd33), R_IDLE, 1);
        for (int i = 0; i < 5; i++) beat(1, 0, rnd(), R_IDLE, 0);
        beat(1, 1, hdr(F_3DW, T_CPL, 10'd0), R_CH, 0);

        // CplD len=16 truncated by a Cpl header
        beat(1, 1, hdr(F_3DW_D, T_CPL, 10'd16), R_CH, 0);
        beat(1, 0, rnd(), R_CD, 0);
        beat(1, 1, hdr(F_3DW, T_CPL, 10'd1), R_CH, 1);
        beat(1, 0, rnd(), R_IDLE, 0);

        // MWr truncated by an unsupported header: two drops in one cycle
        beat(1, 1, hdr(F_3DW_D, T_MEM, 10'd16), R_PH, 0);
        beat(1, 0, rnd(), R_PD, 0);
        beat(1, 1, hdr(F_3DW, T_BAD, 10'd1), R_IDLE, 2);
        beat(1, 0, rnd(), R_IDLE, 0);

        // Unsupported with payload: swallowed, and a sop inside it truncates
        beat(1, 1, hdr(F_4DW_D, T_BAD, 10'd16), R_IDLE, 1);
        beat(1, 0, rnd(), R_IDLE, 0);
        beat(1, 1, hdr(F_3DW, T_MEM, 10'd1), R_NP, 1);
        beat(1, 0, rnd(), R_IDLE, 0);

        // Unsupported without payload stays idle; fmt 001 Cpl is not a supported form
        beat(1, 1, hdr(3'b001, T_CPL, 10'd4), R_IDLE, 1);
        beat(1, 0, rnd(), R_IDLE, 0);

        // len=0 means 1024 DW: oversize, 128 beats swallowed
        beat(1, 1, hdr(F_3DW_D, T_MEM, 10'd0), R_IDLE, 1);
        for (int i = 0; i < 128; i++) beat(1, 0, rnd(), R_IDLE, 0);
        beat(1, 1, hdr(F_3DW, T_MEM, 10'd1), R_NP, 0);

        // Link drop mid MWr payload
        beat(1, 1, hdr(F_3DW_D, T_MEM, 10'd32), R_PH, 0);
        beat(1, 0, rnd(), R_PD, 0);
        beat(1, 0, rnd(), R_PD, 0);
        lk_want = 1'b0;
        beat(1, 0, rnd(), R_IDLE, 0);
        beat(1, 1, hdr(F_3DW, T_MEM, 10'd1), R_IDLE, 0);
        lk_want = 1'b1;
        beat(1, 0, rnd(), R_IDLE, 0);
        beat(1, 1, hdr(F_3DW, T_MEM, 10'd1), R_NP, 0);

        // Reset mid-TLP: remainder becomes orphans, no drop count
        beat(1, 1, hdr(F_3DW_D, T_MEM, 10'd32), R_PH, 0);
        beat(1, 0, rnd(), R_PD, 0);
        idle(1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("mid_rst_req",   {253'd0, req_o},        256'd0);
        check("mid_rst_tlp",   tlp_o,                  256'd0);
        check("mid_rst_pulse", {255'd0, drop_pulse_o}, 256'd0);
        check("mid_rst_cnt",   {248'd0, drop_cnt_o},   256'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        beat(1, 0, rnd(), R_IDLE, 0);
        beat(1, 0, rnd(), R_IDLE, 0);
        beat(1, 1, hdr(F_3DW, T_MEM, 10'd1), R_NP, 0);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) beat(1, 1, hdr(F_3DW, T_BAD, 10'd1), R_IDLE, 1);
        beat(1, 1, hdr(F_3DW_D, T_CPL, 10'd4), R_CH, 0);
        beat(1, 0, rnd(), R_CD, 0);
        idle(2);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drained", {224'd0, 32'(sb.size())}, 256'd0);
        check("sat_final",  {248'd0, drop_cnt_o},     256'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tl_rx_demux.md
TL_RX_DEMUX -- requirements
Module: tl_rx_demux

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD_SIZE, default 128, giving the maximum accepted TLP payload in bytes.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 SHALL have port link_active_i, input, 1, DLL link-up status.
REQ-005 SHALL have port tlp_valid_i, input, 1, which qualifies the input beat from the DLL Rx path after the LCRC check.
REQ-006 SHALL have port tlp_sop_i, input, 1, which marks the first beat of a TLP, the header beat.
REQ-007 SHALL have port tlp_i, input, 256, the TLP beat; the header occupies [127:0] and payload starts on the next beat, 8 DW per beat.
REQ-008 SHALL have port tlp_o, output, 256, the beat forwarded to the TL.
REQ-009 SHALL have port req_o, output, 3, the TL request code: 0 IDLE, 1 P_HDR, 2 P_DATA, 3 NP_HDR, 5 CPL_HDR, 6 CPL_DATA.
REQ-010 SHALL have port drop_pulse_o, output, 1, a one-cycle flag for each dropped TLP.
REQ-011 SHALL have port drop_cnt_o, output, 8, a saturating count of dropped TLPs.

Function
REQ-012 SHALL decode the header beat with fmt = tlp_i[7:5], type = tlp_i[4:0] and len = {tlp_i[17:16], tlp_i[31:24]}; len 0 means 1024 DW.
REQ-013 SHALL classify the header as follows:
- fmt 010/011 with type 00000 is MWr (posted).
- fmt 000/001 with type 00000 is MRd (non-posted).
- fmt 000 with type 01010 is Cpl.
- fmt 010 with type 01010 is CplD.
- Anything else is unsupported.
REQ-014 SHALL compute the payload beat count as ceil(len/8) on a 8-bit counter; len 1024 DW gives 128 beats.
REQ-015 SHALL implement FSM states S_IDLE, S_P_DATA, S_CPL_DATA and S_DROP, with reset state S_IDLE.
REQ-016 SHALL register all outputs, so a valid input beat appears on tlp_o/req_o exactly 1 cycle later; tlp_o SHALL be 0 whenever req_o is IDLE.
REQ-017 On a valid sop beat in S_IDLE, the block SHALL act by type:
- MWr: emit P_HDR and go to S_P_DATA.
- MRd: emit NP_HDR and stay in S_IDLE.
- Cpl: emit CPL_HDR and stay in S_IDLE.
- CplD: emit CPL_HDR and go to S_CPL_DATA.
REQ-018 In S_P_DATA or S_CPL_DATA, each valid non-sop beat SHALL emit P_DATA or CPL_DATA respectively and decrement the beat counter; the last beat (counter 1) SHALL return the FSM to S_IDLE.
REQ-019 Cycles with tlp_valid_i=0 SHALL emit IDLE and leave the FSM and counter unchanged.
REQ-020 An MWr or CplD with len*4 > MAX_PAYLOAD_SIZE SHALL emit nothing, pulse drop_pulse_o, and go to S_DROP for ceil(len/8) beats, which are consumed silently.
REQ-021 An unsupported header SHALL emit nothing and pulse drop_pulse_o; if fmt[1]=1 it SHALL go to S_DROP with the length-derived beat count, otherwise it SHALL stay in S_IDLE.
REQ-022 A valid beat with tlp_sop_i=0 in S_IDLE (orphan) SHALL be discarded silently with no drop count.
REQ-023 A valid sop beat arriving in S_P_DATA, S_CPL_DATA or S_DROP (truncated TLP) SHALL be handled as follows:
- Pulse drop_pulse_o and increment drop_cnt_o once for the truncated TLP.
- In the same cycle, decode the new beat as a header per REQ-017, REQ-020 and REQ-021.
- If the new header is itself dropped, the total count increase SHALL be 2.
REQ-024 drop_cnt_o SHALL increment by the number of drops per cycle and saturate at 255 with no wrap.
REQ-025 While link_active_i=0, the FSM SHALL be forced to S_IDLE, the beat counter cleared, and req_o/tlp_o driven to 0 on the next edge; input beats SHALL be ignored.
REQ-026 The block SHALL have no backpressure; the TL Rx FIFOs are sized by advertised credits.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously drive tlp_o=0, req_o=0, drop_pulse_o=0, drop_cnt_o=0, FSM=S_IDLE and beat counter=0.
REQ-028 On rst_n deassertion, the block SHALL start in S_IDLE; a reset mid-TLP SHALL discard the remainder with no drop count, and subsequent non-sop beats are orphans per REQ-022.

Verification
REQ-029 MWr len=32, then 4 valid beats -> req_o 1,2,2,2,2 on consecutive cycles, each 1 cycle after its input; then IDLE.
REQ-030 MRd header, then CplD len=9 with 2 payload beats and a valid gap of 3 cycles between them -> 3,5,6,(IDLE x3),6; FSM back in S_IDLE.
REQ-031 MWr len=64 with MAX_PAYLOAD_SIZE=128 -> no req_o activity for 9 beats, drop_pulse_o=1 once, drop_cnt_o=1.
REQ-032 CplD len=16, with a sop Cpl header on its 2nd beat -> 5,6,5; drop_cnt_o +1.
REQ-033 300 unsupported headers with fmt 000 -> drop_cnt_o=255, no wrap.
REQ-034 link_active_i dropped mid MWr payload, then restored -> req_o=0 within 1 cycle; the next sop MRd emits 3.
